vga_pattern_gen: RTL and testbench

//   Parametrised VGA raster generator: programmable timing, N colour bars in

---
 rtl/vga_pattern_gen.sv | 142 ++++++++++++++
 tb/tb_vga_pattern_gen.sv | 126 ++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// VGA raster generator: programmable timing, colour bars (vertical/horizontal/checker),
// colour and mode are shadowed at the frame boundary; outputs registered one en-tick behind the counters.
module vga_pattern_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int CW        = 4,
  parameter int NUM_BARS  = 2,
  parameter int CNT_W     = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_BARS*3*CW-1:0] code,
  input  logic [1:0]               mode,
  output logic                     hsync,
  output logic                     vsync,
  output logic [CW-1:0]            red,
  output logic [CW-1:0]            green,
  output logic [CW-1:0]            blue,
  output logic                     de,
  output logic [CNT_W-1:0]         pix_x,
  output logic [CNT_W-1:0]         pix_y,
  output logic                     frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int IW      = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(H_VISIBLE / NUM_BARS - 1);
  localparam logic [CNT_W-1:0] VB_LAST  = CNT_W'(V_VISIBLE / NUM_BARS - 1);
  localparam logic [IW-1:0]    NB_LAST  = IW'(NUM_BARS - 1);
  localparam logic [IW:0]      NB       = (IW + 1)'(NUM_BARS);

  logic [CNT_W-1:0]         h_cnt, v_cnt;
  logic [CNT_W-1:0]         hpos, vpos;
  logic [IW-1:0]            hbar, vbar;
  logic [NUM_BARS*3*CW-1:0] code_q;
  logic [1:0]               mode_q;

  logic                     h_last, v_last, hs_act, vs_act, vis;
  logic [IW:0]              chk_sum;
  logic [IW-1:0]            idx;
  logic [3*CW-1:0]          bar_col;
  logic [3*CW-1:0]          pix_col;

  always_comb begin
    h_last  = (h_cnt == H_LAST);
    v_last  = (v_cnt == V_LAST);
    hs_act  = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs_act  = (v_cnt >= VS_START) && (v_cnt < VS_END);
    vis     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    // Both indices are below NUM_BARS, so one conditional subtract is a full modulo.
    chk_sum = {1'b0, hbar} + {1'b0, vbar};
    if (chk_sum >= NB) chk_sum = chk_sum - NB;
    case (mode_q)
      2'b00:   idx = hbar;
      2'b01:   idx = vbar;
      default: idx = chk_sum[IW-1:0];
    endcase
    bar_col = code_q[int'(idx)*3*CW +: 3*CW];
    pix_col = (vis && mode_q != 2'b11) ? bar_col : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hpos        <= '0;
      vpos        <= '0;
      hbar        <= '0;
      vbar        <= '0;
      code_q      <= '0;
      mode_q      <= 2'b00;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      de          <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
    end else begin
      frame_start <= 1'b0;
      if (en) begin
        {red, green, blue} <= pix_col;
        de          <= vis;
        pix_x       <= h_cnt;
        pix_y       <= v_cnt;
        hsync       <= hs_act ? SYNC_POL : ~SYNC_POL;
        vsync       <= vs_act ? SYNC_POL : ~SYNC_POL;
        frame_start <= (h_cnt == '0) && (v_cnt == '0);
        if (h_last) begin
          h_cnt <= '0;
          hpos  <= '0;
          hbar  <= '0;
          if (v_last) begin
            v_cnt  <= '0;
            vpos   <= '0;
            vbar   <= '0;
            code_q <= code;
            mode_q <= mode;
          end else begin
            v_cnt <= v_cnt + 1'b1;
            if (vpos == VB_LAST && vbar != NB_LAST) begin
              vbar <= vbar + 1'b1;
              vpos <= '0;
            end else begin
              vpos <= vpos + 1'b1;
            end
          end
        end else begin
          h_cnt <= h_cnt + 1'b1;
          // Last bar never advances, so it absorbs the remainder pixels.
          if (hpos == HB_LAST && hbar != NB_LAST) begin
            hbar <= hbar + 1'b1;
            hpos <= '0;
          end else begin
            hpos <= hpos + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomised bench for vga_pattern_gen on a shrunken raster, checked every clock against a pixel-rule model.
module tb_vga_pattern_gen;

  localparam int HV = 20, HFP = 2, HS = 3, HBP = 3;
  localparam int VV = 12, VFP = 1, VS = 2, VBP = 2;
  localparam bit POL = 1'b0;
  localparam int CW = 4, NB = 3, CNT_W = 6;
  localparam int HT = HV + HFP + HS + HBP;
  localparam int VT = VV + VFP + VS + VBP;
  localparam int NCYC = 7000;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en = 1'b0;
  logic [NB*3*CW-1:0]   code = '0;
  logic [1:0]           mode = 2'b00;
  logic                 hsync, vsync, de, frame_start;
  logic [CW-1:0]        red, green, blue;
  logic [CNT_W-1:0]     pix_x, pix_y;

  int total = 0;
  int bad = 0;

  vga_pattern_gen #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(POL), .CW(CW), .NUM_BARS(NB), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .code(code), .mode(mode),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .de(de), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: the pixel position about to be emitted and the shadowed settings.
  int               mh, mv;
  logic [NB*3*CW-1:0] mcode;
  logic [1:0]       mmode;
  logic             e_hs, e_vs, e_de, e_fs;
  logic [3*CW-1:0]  e_rgb;
  int               e_x, e_y;

  function automatic logic [3*CW-1:0] bar_colour(input logic [NB*3*CW-1:0] c, input int i);
    logic [NB*3*CW-1:0] t;
    t = c >> (i * 3 * CW);
    return t[3*CW-1:0];
  endfunction

  function automatic int bar_of(input int p, input int vis);
    int b;
    b = p / (vis / NB);
    return (b > NB - 1) ? NB - 1 : b;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [NB*3*CW-1:0] c, input logic [1:0] m);
    int bi;
    if (r) begin
      mh = 0; mv = 0; mcode = '0; mmode = 2'b00;
      e_hs = ~POL; e_vs = ~POL; e_de = 1'b0; e_fs = 1'b0; e_rgb = '0; e_x = 0; e_y = 0;
    end else if (e) begin
      e_x  = mh;
      e_y  = mv;
      e_de = (mh < HV) && (mv < VV);
      e_hs = (mh >= HV + HFP && mh < HV + HFP + HS) ? POL : ~POL;
      e_vs = (mv >= VV + VFP && mv < VV + VFP + VS) ? POL : ~POL;
      e_fs = (mh == 0) && (mv == 0);
      case (mmode)
        2'b00:   bi = bar_of(mh, HV);
        2'b01:   bi = bar_of(mv, VV);
        default: bi = (bar_of(mh, HV) + bar_of(mv, VV)) % NB;
      endcase
      e_rgb = (e_de && mmode != 2'b11) ? bar_colour(mcode, bi) : '0;
      if (mh == HT - 1 && mv == VT - 1) begin
        mcode = c;
        mmode = m;
      end
      mh = mh + 1;
      if (mh == HT) begin
        mh = 0;
        mv = (mv + 1) % VT;
      end
    end else begin
      e_fs = 1'b0;
    end
  endtask

  initial begin
    logic s_rst, s_en;
    logic [NB*3*CW-1:0] s_code;
    logic [1:0] s_mode;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      rst = (cyc < 3) || (cyc >= 4000 && cyc < 4002);
      if (cyc < 1500)      en = 1'b1;
      else if (cyc < 2500) en = cyc[0];
      else                 en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 59) == 0) begin
        code = {$urandom, $urandom};
        mode = 2'($urandom_range(0, 3));
      end
      s_rst = rst; s_en = en; s_code = code; s_mode = mode;
      @(posedge clk);
      model_step(s_rst, s_en, s_code, s_mode);
      #1;
      check("hsync", 32'(hsync), 32'(e_hs));
      check("vsync", 32'(vsync), 32'(e_vs));
      check("de", 32'(de), 32'(e_de));
      check("pix_x", 32'(pix_x), 32'(e_x));
      check("pix_y", 32'(pix_y), 32'(e_y));
      check("rgb", 32'({red, green, blue}), 32'(e_rgb));
      check("frame_start", 32'(frame_start), 32'(e_fs));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
